// File: rtl/accel_pkg.sv
// Shared definitions for the MAC-array sequencer: default dimensions,
// FSM state encoding and the pipeline flush length.
package accel_pkg;

    localparam int DEFAULT_N   = 8;
    localparam int DEFAULT_K_W = 8;

    // Extra feed steps beyond the reduction length: the skew ramp-in (N-1)
    // plus the zero-filled flush that lets the last lane drain (N-1).
    function automatic int flush_len(input int n);
        return 2 * n - 2;
    endfunction

    localparam int FLUSH_CYCLES = flush_len(DEFAULT_N);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/lane_mask_gen.sv
// Combinational diagonal-skew mask: lane i is live while
// i <= step < i + k. Shared between the row-edge and column-edge feeders.
module lane_mask_gen
    import accel_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int K_W = DEFAULT_K_W
) (
    input  logic [K_W+4:0] step,
    input  logic [K_W-1:0] k,
    output logic [N-1:0]   lane_valid
);

    localparam int STEP_W = K_W + 5;

    // One window comparator per lane.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_valid[i] = (step >= STEP_W'(i)) &&
                            (step <  STEP_W'(i) + STEP_W'(k));
        end
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer for the NxN output-accumulating MAC array: clear, skewed feed,
// flush, then ready/valid drain of result rows. All outputs are registered.
// Optional feature macro: ACCEL_PERF_CNT_EN adds the perf_cycles busy counter.
module systolic_array_ctrl
    import accel_pkg::*;
#(
    parameter int N   = DEFAULT_N,
    parameter int K_W = DEFAULT_K_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 array_rst,
    output logic [K_W+4:0]       step,
    output logic [N-1:0]         lane_valid,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_row,
    input  logic                 out_ready
`ifdef ACCEL_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    localparam int STEP_W = K_W + 5;
    localparam int ROW_W  = $clog2(N);
    localparam int FLUSH  = flush_len(N);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

    state_e              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [ROW_W-1:0]    out_row_q, out_row_d;
    logic [N-1:0]        lane_valid_q, lane_valid_d, mask;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                array_rst_q, array_rst_d;
    logic                out_valid_q, out_valid_d;
    logic [STEP_W-1:0]   last_step;

    // Final feed step index: k + 2N - 3 (only reached with k != 0).
    assign last_step = STEP_W'(k_q) + STEP_W'(FLUSH - 1);

    lane_mask_gen #(
        .N   (N),
        .K_W (K_W)
    ) u_lane_mask (
        .step       (step_d),
        .k          (k_d),
        .lane_valid (mask)
    );

    // Next-state, counters, and next values of the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        k_d       = k_q;
        step_d    = '0;
        out_row_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d     = k_len;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = (k_q != '0) ? ST_FEED : ST_DRAIN;
            end
            ST_FEED: begin
                if (step_q == last_step) begin
                    state_d = ST_DRAIN;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready && (out_row_q == LAST_ROW)) begin
                    state_d = ST_DONE;
                end else if (out_ready) begin
                    out_row_d = out_row_q + ROW_W'(1);
                end else begin
                    out_row_d = out_row_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it.
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        array_rst_d  = (state_d == ST_CLEAR);
        out_valid_d  = (state_d == ST_DRAIN);
        lane_valid_d = (state_d == ST_FEED) ? mask : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            step_q       <= '0;
            out_row_q    <= '0;
            lane_valid_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            array_rst_q  <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            step_q       <= step_d;
            out_row_q    <= out_row_d;
            lane_valid_q <= lane_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            array_rst_q  <= array_rst_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign array_rst  = array_rst_q;
    assign step       = step_q;
    assign lane_valid = lane_valid_q;
    assign out_valid  = out_valid_q;
    assign out_row    = out_row_q;

`ifdef ACCEL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: reload on accept, saturating count while busy.
    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_IDLE) && start) begin
            perf_d = '0;
        end else if (busy_q && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: nominal job, zero length,
// backpressure, ignored start, mid-job reset, maximum length.
module tb_systolic_array_ctrl;

    localparam int N   = 8;
    localparam int K_W = 8;
    localparam int MAXC = 600;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [K_W-1:0] k_len;
    logic           busy, done, array_rst, out_valid, out_ready;
    logic [K_W+4:0] step;
    logic [N-1:0]   lane_valid;
    logic [2:0]     out_row;
`ifdef ACCEL_PERF_CNT_EN
    logic [31:0]    perf_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Per-cycle log of the last job, indexed by cycles after the accept edge.
    logic [K_W+4:0] step_log  [0:MAXC];
    logic [N-1:0]   lane_log  [0:MAXC];
    logic           arst_log  [0:MAXC];
    logic           oval_log  [0:MAXC];
    logic [2:0]     row_log   [0:MAXC];

    systolic_array_ctrl #(.N(N), .K_W(K_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .done       (done),
        .array_rst  (array_rst),
        .step       (step),
        .lane_valid (lane_valid),
        .out_valid  (out_valid),
        .out_row    (out_row),
        .out_ready  (out_ready)
`ifdef ACCEL_PERF_CNT_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job; cycle 1 is the first cycle after the accept edge.
    // bp_row/bp_len: hold out_ready low for bp_len cycles on that row.
    // inj_at: cycle at which a stray start (k_len=5) is pulsed.
    task automatic run_job(input int k, input int bp_row, input int bp_len, input int inj_at,
                           output int done_at, output int feed_cyc, output int busy_cyc,
                           output logic lane_any);
        int   held;
        logic prev_low;
        done_at = -1; feed_cyc = 0; busy_cyc = 0; lane_any = 1'b0;
        held = 0; prev_low = 1'b0;
        start = 1'b1; k_len = K_W'(k); out_ready = 1'b1;
        tick();
        start = 1'b0;
        k_len = 8'hAA;
        for (int c = 1; c <= MAXC; c++) begin
            step_log[c] = step; lane_log[c] = lane_valid; arst_log[c] = array_rst;
            oval_log[c] = out_valid; row_log[c] = out_row;
            if (busy) busy_cyc++;
            if (lane_valid != '0) lane_any = 1'b1;
            if (busy && !array_rst && !out_valid && !done) feed_cyc++;
            if (prev_low) begin
                check("bp_row_hold", 32'(out_row), 32'(bp_row));
                check("bp_valid_hold", 32'(out_valid), 32'd1);
            end
            if (done) begin
                done_at = c;
                break;
            end
            start = (c == inj_at);
            if (c == inj_at) k_len = 8'd5;
            out_ready = 1'b1;
            prev_low  = 1'b0;
            if (out_valid && (int'(out_row) == bp_row) && (held < bp_len)) begin
                out_ready = 1'b0;
                prev_low  = 1'b1;
                held++;
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int   d, f, b;
        logic la, seen, bad;

        rst = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_array_rst", 32'(array_rst), 32'd1);
        check("rst_step", 32'(step), 32'd0);
        check("rst_lane", 32'(lane_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_row", 32'(out_row), 32'd0);
`ifdef ACCEL_PERF_CNT_EN
        check("rst_perf", perf_cycles, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Nominal job, k=8.
        run_job(8, -1, 0, -1, d, f, b, la);
        check("nom_done_at", 32'(d), 32'd32);
        check("nom_busy_cycles", 32'(b), 32'd32);
        check("nom_feed_cycles", 32'(f), 32'd22);
        check("nom_clear_t1", 32'(arst_log[1]), 32'd1);
        check("nom_step0", 32'(step_log[2]), 32'd0);
        check("nom_lane_s0", 32'(lane_log[2]), 32'h01);
        check("nom_lane_s7", 32'(lane_log[9]), 32'hFF);
        check("nom_lane_s8", 32'(lane_log[10]), 32'hFE);
        check("nom_step21", 32'(step_log[23]), 32'd21);
        bad = 1'b0;
        for (int c = 17; c <= 23; c++) if (lane_log[c] != '0) bad = 1'b1;
        check("nom_lane_flush_zero", 32'(bad), 32'd0);
        check("nom_valid_t23", 32'(oval_log[23]), 32'd0);
        for (int c = 24; c <= 31; c++) begin
            check("nom_out_valid", 32'(oval_log[c]), 32'd1);
            check("nom_out_row", 32'(row_log[c]), 32'(c - 24));
        end
        check("nom_step_drain", 32'(step_log[24]), 32'd0);
        tick();
        check("nom_idle_busy", 32'(busy), 32'd0);
        check("nom_done_pulse", 32'(done), 32'd0);

        // Zero length.
        tick();
        run_job(0, -1, 0, -1, d, f, b, la);
        check("zero_done_at", 32'(d), 32'd10);
        check("zero_no_lane", 32'(la), 32'd0);
        check("zero_feed_cycles", 32'(f), 32'd0);
        check("zero_drain_t2", 32'(oval_log[2]), 32'd1);
        check("zero_row_t2", 32'(row_log[2]), 32'd0);
        tick();

        // Backpressure on row 2 for 4 cycles.
        run_job(3, 2, 4, -1, d, f, b, la);
        check("bp_done_at", 32'(d), 32'd31);
        tick();

        // Stray start during FEED is ignored.
        run_job(8, -1, 0, 5, d, f, b, la);
        check("ign_done_at", 32'(d), 32'd32);
        check("ign_feed_cycles", 32'(f), 32'd22);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) bad = 1'b1;
        end
        check("ign_no_second_job", 32'(bad), 32'd0);

        // Reset during DRAIN row 3.
        start = 1'b1; k_len = 8'd8;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_row == 3'd3) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("mid_reached_row3", 32'(seen), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_array_rst", 32'(array_rst), 32'd1);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_out_row", 32'(out_row), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || busy) bad = 1'b1;
        end
        check("mid_no_done", 32'(bad), 32'd0);
        run_job(1, -1, 0, -1, d, f, b, la);
        check("mid_k1_done_at", 32'(d), 32'd25);
        tick();

        // Maximum length.
        run_job(255, -1, 0, -1, d, f, b, la);
        check("max_done_at", 32'(d), 32'd279);
        check("max_feed_cycles", 32'(f), 32'd269);
        tick();
`ifdef ACCEL_PERF_CNT_EN
        check("max_perf", perf_cycles, 32'd279);
        tick(); tick(); tick();
        check("max_perf_hold", perf_cycles, 32'd279);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
